// File: rtl/hex_display_arbiter_if.sv
// rtl/hex_display_arbiter_if.sv - request/display bus between requesters and the hex display arbiter
// Purpose: bundles the per-requester valid/data/ready handshake and the display
//          write port so the arbiter takes a single bus port.
// Ports (signals):
//   i_valid  NUM_REQ      per-requester write request (requester side drives)
//   i_data   16*NUM_REQ   request payloads, requester k at [16k+15:16k]
//   o_ready  NUM_REQ      one-hot accept from the arbiter
//   o_data   16           registered display value
//   o_we     1            one-cycle display write strobe
//   o_owner  IDX_W        requester index of the last write
//   o_busy   1            dwell window running
// Modports: master = requester/display side, slave = arbiter.
interface hex_display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    i_valid;
  logic [16*NUM_REQ-1:0] i_data;
  logic [NUM_REQ-1:0]    o_ready;
  logic [15:0]           o_data;
  logic                  o_we;
  logic [IDX_W-1:0]      o_owner;
  logic                  o_busy;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_data, o_we, o_owner, o_busy
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_data, o_we, o_owner, o_busy
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin arbiter with dwell time for the 4-digit hex display
// Purpose: shares the single 16-bit display write port among NUM_REQ requesters.
//          Round-robin grant in IDLE, then a HOLD window of HOLD_CYCLES clocks
//          during which nothing is accepted, so each value stays visible.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous reset, active-low
//   bus    slave modport of hex_display_arbiter_if (i_valid, i_data in;
//          o_ready combinational; o_data, o_we, o_owner registered; o_busy)
// Configuration macro: HEX_ARB_PRIO0_EN - requester 0 gets strict priority and
//          does not move the round-robin pointer; others round-robin among themselves.
module hex_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hex_display_arbiter_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

`ifdef HEX_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [15:0]       r_data;
  logic              r_we;
  logic [IDX_W-1:0]  r_owner;

  logic              w_found;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [IDX_W-1:0]  w_cand;
  logic [NUM_REQ-1:0] w_ready;
  logic              w_fire;

  // Explicit modulo so non-power-of-two NUM_REQ wraps correctly.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // Requester search starting at rr_ptr; in priority mode port 0 is excluded
  // from the rotation and overrides it when requesting.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = wrap_idx(int'(r_rr_ptr) + i);
      if (!w_found && bus.i_valid[w_cand] && (!PRIO0 || (w_cand != '0))) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    if (PRIO0 && bus.i_valid[0]) begin
      w_found     = 1'b1;
      w_grant_idx = '0;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rr_ptr_nxt = r_rr_ptr;
    w_ready      = '0;
    case (r_state)
      S_IDLE: begin
        // Gated by rst_n so nothing is offered while reset is held.
        if (rst_n && w_found) begin
          w_ready[w_grant_idx] = 1'b1;
          w_state_nxt          = S_HOLD;
          w_cnt_nxt            = CNT_W'(HOLD_CYCLES);
          if (!(PRIO0 && (w_grant_idx == '0))) begin
            w_rr_ptr_nxt = wrap_idx(int'(w_grant_idx) + 1);
          end
        end
      end
      S_HOLD: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fire = |(bus.i_valid & w_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_we     <= w_fire;
      if (w_fire) begin
        r_data  <= bus.i_data[16*int'(w_grant_idx) +: 16];
        r_owner <= w_grant_idx;
      end
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_data  = r_data;
  assign bus.o_we    = r_we;
  assign bus.o_owner = r_owner;
  assign bus.o_busy  = (r_state == S_HOLD);
endmodule
